instruction_fetch: RTL



---
 rtl/instruction_fetch.sv | 135 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the 8-bit core: one-outstanding-request memory port
// feeding a small prefetch FIFO of {address, instruction} pairs, flushed on redirect.
module instruction_fetch #(
  parameter int          DEPTH      = 4,
  parameter logic [7:0]  RESET_ADDR = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic       instr_valid,
  output logic [7:0] instruction,
  output logic [7:0] instruction_address,
  input  logic       instr_ready,
  input  logic       redirect,
  input  logic [7:0] redirect_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDiscard
  } fetchState_e;

  fetchState_e      state_q;
  logic [7:0]       fpc_q;
  logic             memReq_q;
  logic [7:0]       memAddr_q;

  logic [7:0]       addrMem_q [DEPTH];
  logic [7:0]       dataMem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pushEn;
  logic             popEn;

  assign pushEn = (state_q == StWait) && mem_ack && !redirect;
  assign popEn  = instr_valid && instr_ready && !redirect;

  assign mem_req             = memReq_q;
  assign mem_addr            = memAddr_q;
  assign instr_valid         = (count_q != '0);
  assign instruction         = dataMem_q[rdPtr_q];
  assign instruction_address = addrMem_q[rdPtr_q];

  // Issue only when a free slot exists for the one request that may be in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      fpc_q     <= RESET_ADDR;
      memReq_q  <= 1'b0;
      memAddr_q <= 8'h00;
    end else begin
      if (redirect) begin
        fpc_q <= redirect_addr;
      end
      unique case (state_q)
        StIdle: begin
          if (!redirect && (count_q < CNT_W'(DEPTH))) begin
            memReq_q  <= 1'b1;
            memAddr_q <= fpc_q;
            fpc_q     <= fpc_q + 8'd1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_ack) begin
            memReq_q <= 1'b0;
            state_q  <= StIdle;
          end else if (redirect) begin
            state_q <= StDiscard;
          end
        end
        StDiscard: begin
          if (mem_ack) begin
            memReq_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (redirect) begin
      rdPtr_d = '0;
      wrPtr_d = '0;
      count_d = '0;
    end else begin
      if (pushEn) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (popEn) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end
      unique case ({pushEn, popEn})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addrMem_q[i] <= 8'h00;
        dataMem_q[i] <= 8'h00;
      end
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
      if (pushEn) begin
        addrMem_q[wrPtr_q] <= mem_addr;
        dataMem_q[wrPtr_q] <= mem_data;
      end
    end
  end

endmodule
